// File: rtl/instr_feeder_pkg.sv
// Shared constants for the instruction feeder: opcodes, halt word, FSM codes.
package instr_feeder_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MV  = 3'b110;
    localparam logic [2:0] OP_MVI = 3'b111;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_IMM   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    function automatic logic is_mvi(input logic [15:0] w);
        return w[8:6] == OP_MVI;
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Processor-side bus of the feeder: instruction word, issue strobe, done flag.
interface instr_feeder_if;

    logic [15:0] DIN;
    logic        Run;
    logic        Done;

    modport master (output DIN, output Run, input Done);
    modport slave  (input DIN, input Run, output Done);

endinterface

// File: rtl/instr_mem.sv
// Program memory: one write port, one synchronous read port.
module instr_mem #(
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [2**ADDR_W];

    // Array has no reset so a program survives Reset.
    always_ff @(posedge Clock) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder FSM: fetches program words and issues them to a processor.
// Optional Done timeout enabled by defining INSTR_FEEDER_TIMEOUT_EN.
module instr_feeder
    import instr_feeder_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [15:0]       LoadData,
    instr_feeder_if.master    cpu,
    output logic              Busy,
    output logic              Halted,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        IssueCount,
    output logic              Error
);

    logic [2:0]        state;
    logic [15:0]       iw;
    logic [15:0]       din_q;
    logic              mvi_q;
    logic              re;
    logic              issue_ok;
    logic              tmo_hit;
    logic [ADDR_W-1:0] raddr;

    // iw is the read register of the memory; in IMM it holds the immediate.
    instr_mem #(.ADDR_W(ADDR_W)) u_mem (
        .Clock (Clock),
        .Reset (Reset),
        .we    (LoadEn && !Busy),
        .waddr (LoadAddr),
        .wdata (LoadData),
        .re    (re),
        .raddr (raddr),
        .rdata (iw)
    );

    assign Busy     = !(state == S_IDLE || state == S_HALT);
    assign Halted   = (state == S_HALT);
    assign issue_ok = (state == S_ISSUE) && (iw != HALT_WORD);
    assign re       = (state == S_FETCH) || (issue_ok && is_mvi(iw));
    assign raddr    = (state == S_FETCH) ? PC : PC + 1'b1;

    always_comb begin
        cpu.Run = 1'b0;
        cpu.DIN = din_q;
        if (issue_ok) begin
            cpu.Run = 1'b1;
            cpu.DIN = iw;
        end else if (state == S_IMM) begin
            cpu.DIN = iw;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            PC         <= '0;
            IssueCount <= '0;
            din_q      <= '0;
            mvi_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (Start) begin
                        PC         <= '0;
                        IssueCount <= '0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_ISSUE;
                S_ISSUE: begin
                    if (iw == HALT_WORD) begin
                        state <= S_HALT;
                    end else begin
                        din_q <= iw;
                        mvi_q <= is_mvi(iw);
                        state <= is_mvi(iw) ? S_IMM : S_WAIT;
                    end
                end
                S_IMM: begin
                    din_q <= iw;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cpu.Done) begin
                        if (IssueCount != 8'hFF)
                            IssueCount <= IssueCount + 8'd1;
                        PC    <= PC + ADDR_W'(mvi_q ? 2 : 1);
                        state <= S_FETCH;
                    end else if (tmo_hit) begin
                        state <= S_HALT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INSTR_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo;
    logic          err_q;

    assign tmo_hit = (state == S_WAIT) && !cpu.Done
                     && (int'(tmo) + 1 >= TIMEOUT_CYCLES);
    assign Error   = err_q;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmo   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state != S_WAIT) tmo <= '0;
            else if (!cpu.Done)  tmo <= tmo + 1'b1;
            if (!Busy && Start)  err_q <= 1'b0;
            else if (tmo_hit)    err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign Error   = 1'b0;
`endif

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Parameter ADDR_W, 5, program-memory address width; depth is 2**ADDR_W words.
REQ-002 Parameter TIMEOUT_CYCLES, 255, maximum WAIT cycles for Done; used only when INSTR_FEEDER_TIMEOUT_EN is defined.
REQ-003 Clock  in  1  single clock; all state updates on posedge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  one-cycle pulse that begins program execution from address 0.
REQ-006 LoadEn  in  1  program-memory write strobe.
REQ-007 LoadAddr  in  ADDR_W  program-memory write address.
REQ-008 LoadData  in  16  program-memory write data.
REQ-009 Done  in  1  processor instruction-complete flag.
REQ-010 DIN  out  16  instruction or immediate word driven to the processor.
REQ-011 Run  out  1  one-cycle instruction-issue strobe.
REQ-012 Busy  out  1  high in every state except IDLE and HALT.
REQ-013 Halted  out  1  high in HALT.
REQ-014 PC  out  ADDR_W  current program address.
REQ-015 IssueCount  out  8  number of instructions completed since Start, saturating at 255.
REQ-016 Error  out  1  Done-timeout flag.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, ISSUE, IMM, WAIT and HALT.
REQ-018 In IDLE or HALT, a Start pulse SHALL clear PC and IssueCount and move to FETCH; Start SHALL be ignored in all other states.
REQ-019 FETCH SHALL perform a synchronous read of mem[PC] into the instruction register IW and move to ISSUE.
REQ-020 If IW equals 16'hFFFF, ISSUE SHALL move to HALT without asserting Run.
REQ-021 Otherwise, ISSUE SHALL drive DIN=IW with Run=1 for exactly one cycle.
REQ-022 From ISSUE, the FSM SHALL move to IMM if IW[8:6]==3'b111 (mvi), else to WAIT.
REQ-023 IMM SHALL drive DIN=mem[PC+1] with Run=0 for one cycle, then move to WAIT.
REQ-024 In WAIT, DIN SHALL hold its last value; when Done==1 the FSM SHALL increment IssueCount, advance PC by 2 for mvi or by 1 otherwise, and move to FETCH.
REQ-025 Done SHALL be ignored outside WAIT.
REQ-026 PC arithmetic SHALL be modulo 2**ADDR_W (PC 31 + 1 = 0; an mvi at PC 31 takes its immediate from address 0).
REQ-027 Run SHALL be 0 in every state except ISSUE.
REQ-028 A LoadEn write SHALL take effect only when Busy==0; writes while Busy SHALL be dropped.
REQ-029 If LoadEn and Start occur in the same cycle in IDLE, the write SHALL complete and FETCH SHALL read the updated word.
REQ-030 Latency: Start at cycle n SHALL produce Run=1 at cycle n+2.

Reset
REQ-031 Reset SHALL force state IDLE with PC=0, IssueCount=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0 and IW=0, asynchronously and regardless of the current state.
REQ-032 Reset SHALL NOT clear the program-memory contents.
REQ-033 A Reset asserted mid-WAIT SHALL abandon the in-flight instruction, and no Run SHALL follow until a new Start.

Configuration
REQ-034 With INSTR_FEEDER_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle with Done==0.
REQ-035 With INSTR_FEEDER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL set Error=1 and move the FSM to HALT.
REQ-036 With INSTR_FEEDER_TIMEOUT_EN defined, Error SHALL remain set until Reset or the next Start.
REQ-037 Without INSTR_FEEDER_TIMEOUT_EN, no counter SHALL exist, Error SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-038 A shared package SHALL hold the opcode constants (ADD 000, SUB 001, OR 010, SLT 011, SLL 100, SRL 101, MV 110, MVI 111), HALT_WORD 16'hFFFF and the FSM state encoding.
REQ-039 Program memory SHALL be a sub-module instr_mem (synchronous read, single write port); the FSM, PC and counters SHALL reside in instr_feeder.

Verification
REQ-040 Load {0:16'h0001 add, 1:FFFF}, pulse Start, return Done 3 cycles after Run -> one Run with DIN=0001, then Halted=1, IssueCount=1, PC=1.
REQ-041 Load {0:16'h01C0 mvi, 1:16'h00AB, 2:FFFF} -> Run with DIN=01C0, next cycle DIN=00AB with Run=0, after Done PC=2, then Halted=1.
REQ-042 Place an mvi at address 31 with mem[0]=16'h1234 -> immediate 1234 issued and PC wraps to 1.
REQ-043 Assert Reset while in WAIT with Done held 0 -> all outputs return to reset values immediately; a later Start runs from address 0.
REQ-044 LoadEn to address 0 with 16'hBEEF while Busy -> the write is dropped and the reread shows the old value.
REQ-045 With INSTR_FEEDER_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, never assert Done -> Error=1 and Halted=1 exactly 4 cycles after WAIT entry; without the macro, Busy stays 1.
